// File: rtl/alu_result_checker.sv
// alu_result_checker: consumer end of the ALU stimulus interface.
// Captures each accepted A/B/ALUop vector together with the DUT ALU outputs,
// compares them with a built-in reference model two cycles later, keeps
// saturating pass/fail/skip statistics and snapshots the first mismatch.
//
// Handshake: a vector transfers on a cycle where in_valid & in_ready are both
// high; in_ready depends only on internal state, never on in_valid, and the
// producer must hold A/B/ALUop/dut_* stable while in_valid waits for in_ready.
module alu_result_checker #(
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 20,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_vec,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    input  logic [DATA_WIDTH-1:0] dut_result,
    input  logic                  dut_overflow,
    input  logic                  dut_carryout,
    input  logic                  dut_zero,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [CNT_WIDTH-1:0]  skip_cnt,
    output logic                  error,
    output logic                  done,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] ff_a,
    output logic [DATA_WIDTH-1:0] ff_b,
    output logic [2:0]            ff_op,
    output logic [DATA_WIDTH-1:0] ff_got,
    output logic [DATA_WIDTH-1:0] ff_exp,
    output logic [1:0]            dbg_state
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t state, state_n;

    logic [CNT_WIDTH-1:0]  target, issued;

    // S1: vector as accepted
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_a, s1_b, s1_res;
    logic [2:0]            s1_op;
    logic                  s1_ovf, s1_co, s1_zero;

    // S2: vector under comparison
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_a, s2_b, s2_res;
    logic [2:0]            s2_op;
    logic                  s2_ovf, s2_co, s2_zero;

    // reference model results for the S2 vector
    logic [DATA_WIDTH:0]   add_full;
    logic [DATA_WIDTH-1:0] sub_res;
    logic [DATA_WIDTH-1:0] exp_res;
    logic                  exp_co, exp_ovf, exp_zero, chk_cv, op_skip, mism;

    logic accept, begin_run, halt_now;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign in_ready  = (state == S_RUN) && (issued < target);
    assign accept    = in_valid && in_ready;
    assign begin_run = start && (state != S_RUN);
    assign halt_now  = (STOP_ON_FAIL != 0) && s2_valid && mism;
    assign done      = (state == S_DONE);
    assign halted    = (state == S_HALT);
    assign dbg_state = state;

    assign add_full  = {1'b0, s2_a} + {1'b0, s2_b};
    assign sub_res   = s2_a - s2_b;

    // Reference model and comparison of the vector sitting in S2
    always_comb begin
        exp_res = '0;
        exp_co  = 1'b0;
        exp_ovf = 1'b0;
        chk_cv  = 1'b0;
        op_skip = 1'b0;
        case (s2_op)
            3'b000: exp_res = s2_a & s2_b;
            3'b001: exp_res = s2_a | s2_b;
            3'b010: begin
                exp_res = add_full[MSB:0];
                exp_co  = add_full[DATA_WIDTH];
                exp_ovf = (s2_a[MSB] == s2_b[MSB]) && (add_full[MSB] != s2_a[MSB]);
                chk_cv  = 1'b1;
            end
            3'b110: begin
                exp_res = sub_res;
                exp_co  = (s2_a < s2_b);
                exp_ovf = (s2_a[MSB] != s2_b[MSB]) && (sub_res[MSB] != s2_a[MSB]);
                chk_cv  = 1'b1;
            end
            3'b111: exp_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(s2_a) < $signed(s2_b))};
            default: op_skip = 1'b1;
        endcase
        exp_zero = (exp_res == '0);
        mism = !op_skip && ((s2_res != exp_res) || (s2_zero != exp_zero) ||
                            (chk_cv && ((s2_co != exp_co) || (s2_ovf != exp_ovf))));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; DONE once everything is issued and the last vector
    // leaves S2 on this edge (S1 empty, no further accepts possible)
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE, S_HALT: begin
                if (start) state_n = (num_vec == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (halt_now)                                state_n = S_HALT;
                else if ((issued == target) && !s1_valid)    state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Run bookkeeping, pipeline stages, statistics and first-fail capture
    always_ff @(posedge clk) begin
        if (rst) begin
            target   <= '0;
            issued   <= '0;
            s1_valid <= 1'b0;
            s1_a <= '0; s1_b <= '0; s1_res <= '0; s1_op <= '0;
            s1_ovf <= 1'b0; s1_co <= 1'b0; s1_zero <= 1'b0;
            s2_valid <= 1'b0;
            s2_a <= '0; s2_b <= '0; s2_res <= '0; s2_op <= '0;
            s2_ovf <= 1'b0; s2_co <= 1'b0; s2_zero <= 1'b0;
            pass_cnt <= '0; fail_cnt <= '0; skip_cnt <= '0;
            error <= 1'b0;
            ff_a <= '0; ff_b <= '0; ff_op <= '0; ff_got <= '0; ff_exp <= '0;
        end else if (begin_run) begin
            target   <= num_vec;
            issued   <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            pass_cnt <= '0; fail_cnt <= '0; skip_cnt <= '0;
            error <= 1'b0;
            ff_a <= '0; ff_b <= '0; ff_op <= '0; ff_got <= '0; ff_exp <= '0;
        end else begin
            if (accept) issued <= issued + CNT_ONE;
            // a halting mismatch discards whatever is behind it
            s1_valid <= accept && !halt_now;
            if (accept) begin
                s1_a <= A; s1_b <= B; s1_op <= ALUop; s1_res <= dut_result;
                s1_ovf <= dut_overflow; s1_co <= dut_carryout; s1_zero <= dut_zero;
            end
            s2_valid <= s1_valid && !halt_now;
            if (s1_valid) begin
                s2_a <= s1_a; s2_b <= s1_b; s2_op <= s1_op; s2_res <= s1_res;
                s2_ovf <= s1_ovf; s2_co <= s1_co; s2_zero <= s1_zero;
            end
            if (s2_valid) begin
                if (op_skip) begin
                    skip_cnt <= sat_inc(skip_cnt);
                end else if (mism) begin
                    fail_cnt <= sat_inc(fail_cnt);
                    if (!error) begin
                        error  <= 1'b1;
                        ff_a   <= s2_a;
                        ff_b   <= s2_b;
                        ff_op  <= s2_op;
                        ff_got <= s2_res;
                        ff_exp <= exp_res;
                    end
                end else begin
                    pass_cnt <= sat_inc(pass_cnt);
                end
            end
        end
    end

endmodule
